// File: rtl/packet_ejector.sv
// packet_ejector: sink endpoint for a PE local port.
// Accepts router packets over Req/Gnt/Full, buffers them in a first-word
// fall-through FIFO, and presents them to the PE with valid/ready.
// Keeps receive statistics.
// Optional macro SEQ_CHECK_EN adds per-source PacketID sequence checking.
module packet_ejector #(
  parameter logic [5:0] ModuleID    = 6'b001_001,
  parameter int         packetwidth = 56,
  parameter int         DEPTH       = 4,
  parameter int         PTR_W       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqUpStr,
  input  logic [packetwidth-1:0] PacketIn,
  output logic                   GntUpStr,
  output logic                   UpStrFull,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [packetwidth-1:0] pkt_data,
  output logic [5:0]             pkt_src,
  output logic [9:0]             pkt_id,
  output logic [15:0]            rx_count,
  output logic [5:0]             last_src,
  output logic [5:0]             my_id,
  output logic [7:0]             seq_err_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GRANT    = 2'b01,
    ACK_WAIT = 2'b10
  } state_t;

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   nonempty_s;
  logic                   gnt_nxt_s;
  logic                   gnt_r;
  logic [packetwidth-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [PTR_W:0]         count_r;
  logic [packetwidth-1:0] head_s;
  logic [15:0]            rx_count_r;
  logic [5:0]             last_src_r;

  assign full_s     = (count_r == DEPTH_C);
  assign nonempty_s = (count_r != {(PTR_W+1){1'b0}});
  // A pop needs a valid head; a pop while full never frees room for a push on the same edge.
  assign pop_s      = nonempty_s && pkt_ready;

  // Next-state logic: capture only from IDLE with room, grant for one cycle, then wait for the request to drop.
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    gnt_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ReqUpStr && !full_s) begin
          push_s      = 1'b1;
          gnt_nxt_s   = 1'b1;
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        state_nxt_s = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (ReqUpStr) begin
          state_nxt_s = ACK_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and registered grant pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      gnt_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= gnt_nxt_s;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= PacketIn;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Receive statistics updated on every accepted packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_count_r <= 16'd0;
      last_src_r <= 6'd0;
    end else if (push_s) begin
      rx_count_r <= rx_count_r + 16'd1;
      last_src_r <= PacketIn[15:10];
    end
  end

`ifdef SEQ_CHECK_EN
  logic [9:0]  exp_id_r [64];
  logic [63:0] seen_r;
  logic [7:0]  seq_err_r;
  logic [5:0]  in_src_s;
  logic [9:0]  in_id_s;

  assign in_src_s = PacketIn[15:10];
  assign in_id_s  = PacketIn[25:16];

  // Per-source sequence tracking; the first packet from a source only seeds the table.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin
        exp_id_r[i] <= 10'd0;
      end
      seen_r    <= 64'd0;
      seq_err_r <= 8'd0;
    end else if (push_s) begin
      if (seen_r[in_src_s] && (in_id_s != exp_id_r[in_src_s]) && (seq_err_r != 8'hFF)) begin
        seq_err_r <= seq_err_r + 8'd1;
      end
      exp_id_r[in_src_s] <= in_id_s + 10'd1;
      seen_r[in_src_s]   <= 1'b1;
    end
  end

  assign seq_err_count = seq_err_r;
`else
  assign seq_err_count = 8'd0;
`endif

  assign head_s    = nonempty_s ? mem_r[rd_ptr_r] : {packetwidth{1'b0}};
  assign GntUpStr  = gnt_r;
  assign UpStrFull = full_s;
  assign pkt_valid = nonempty_s;
  assign pkt_data  = head_s;
  assign pkt_src   = head_s[15:10];
  assign pkt_id    = head_s[25:16];
  assign rx_count  = rx_count_r;
  assign last_src  = last_src_r;
  assign my_id     = ModuleID;

endmodule

// File: tb/tb_packet_ejector.sv
// Testbench for packet_ejector: directed steps followed by randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_packet_ejector;

  localparam int PW    = 56;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ReqUpStr = 1'b0;
  logic [PW-1:0] PacketIn = '0;
  logic          pkt_ready = 1'b0;
  logic          GntUpStr, UpStrFull, pkt_valid;
  logic [PW-1:0] pkt_data;
  logic [5:0]    pkt_src, last_src, my_id;
  logic [9:0]    pkt_id;
  logic [15:0]   rx_count;
  logic [7:0]    seq_err_count;

  packet_ejector #(
    .ModuleID(6'b001_001), .packetwidth(PW), .DEPTH(DEPTH), .PTR_W(2)
  ) dut (
    .clk(clk), .reset(reset), .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
    .GntUpStr(GntUpStr), .UpStrFull(UpStrFull), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_data(pkt_data), .pkt_src(pkt_src),
    .pkt_id(pkt_id), .rx_count(rx_count), .last_src(last_src),
    .my_id(my_id), .seq_err_count(seq_err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PW-1:0] mq[$];
  int            rx_m;
  logic [5:0]    last_m;
  int            seq_m;
  int            exp_m [64];
  bit            seen_m [64];
  bit            busy_m;
  bit            gnt_m;

  task automatic model_reset();
    mq.delete();
    rx_m = 0; last_m = 6'd0; seq_m = 0; busy_m = 1'b0; gnt_m = 1'b0;
    for (int i = 0; i < 64; i++) begin
      exp_m[i] = 0; seen_m[i] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [9:0] id, input logic [5:0] src);
    logic [63:0] r;
    r = {$urandom, $urandom};
    mk = {r[29:0], id, src, r[41:32]};
  endfunction

  task automatic check_all();
    logic [PW-1:0] h;
    int            seq_exp;
    h = (mq.size() != 0) ? mq[0] : '0;
`ifdef SEQ_CHECK_EN
    seq_exp = seq_m;
`else
    seq_exp = 0;
`endif
    chk("gnt",      64'(GntUpStr),      64'(gnt_m));
    chk("full",     64'(UpStrFull),     64'(mq.size() == DEPTH));
    chk("valid",    64'(pkt_valid),     64'(mq.size() != 0));
    chk("data",     64'(pkt_data),      64'(h));
    chk("src",      64'(pkt_src),       64'(h[15:10]));
    chk("id",       64'(pkt_id),        64'(h[25:16]));
    chk("rx_count", 64'(rx_count),      64'(rx_m));
    chk("last_src", 64'(last_src),      64'(last_m));
    chk("seq_err",  64'(seq_err_count), 64'(seq_exp));
    chk("my_id",    64'(my_id),         64'(6'b001_001));
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic tick(input logic req, input logic [PW-1:0] pkt, input logic rdy, output bit acc);
    bit         pop;
    logic [5:0] s;
    int         id;
    ReqUpStr  = req;
    PacketIn  = pkt;
    pkt_ready = rdy;
    acc = req && !busy_m && (mq.size() < DEPTH);
    pop = rdy && (mq.size() > 0);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(pkt);
      rx_m   = (rx_m + 1) % 65536;
      last_m = pkt[15:10];
      s  = pkt[15:10];
      id = int'(pkt[25:16]);
      if (seen_m[s] && id != exp_m[s] && seq_m < 255) seq_m++;
      exp_m[s]  = (id + 1) % 1024;
      seen_m[s] = 1'b1;
      busy_m = 1'b1;
      gnt_m  = 1'b1;
    end else if (gnt_m) begin
      gnt_m = 1'b0;
    end else if (busy_m && !req) begin
      busy_m = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  // Router behaviour: hold the request until granted, keep it one more cycle, then drop it.
  // rmode: 0 = ready low, 1 = ready high, 2 = random ready.
  task automatic send(input logic [PW-1:0] pkt, input int rmode);
    bit   acc;
    logic r;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      r = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
      tick(1'b1, pkt, r, acc);
    end
    chk("send_granted", 64'(acc), 64'(1));
    r = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
    tick(1'b1, pkt, r, acc);
    r = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
    tick(1'b0, '0, r, acc);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 8; k++) tick(1'b0, '0, 1'b1, acc);
  endtask

  initial begin : stim
    bit            acc;
    logic [PW-1:0] p5, pc;
    int            nid [8];
    int            id;
    logic [5:0]    src;
    int            exp_seq;

    model_reset();
    // Reset state
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;
    tick(1'b0, '0, 1'b0, acc);
    tick(1'b0, '0, 1'b1, acc);

    // Single packet, no double capture
    send(mk(10'd5, 6'b010_001), 0);
    tick(1'b0, '0, 1'b0, acc);
    chk("single_id",  64'(pkt_id),   64'(10'd5));
    chk("single_src", 64'(pkt_src),  64'(6'b010_001));
    chk("single_rx",  64'(rx_count), 64'(16'd1));
    chk("single_last",64'(last_src), 64'(6'b010_001));
    drain();

    // Fill to full, hold fifth request, single pop releases it
    for (int i = 1; i <= 4; i++) send(mk(10'(i), 6'b000_010), 0);
    chk("full_after4", 64'(UpStrFull), 64'(1));
    p5 = mk(10'd5, 6'b000_010);
    for (int k = 0; k < 3; k++) tick(1'b1, p5, 1'b0, acc);
    chk("no_gnt_full", 64'(GntUpStr), 64'(0));
    tick(1'b1, p5, 1'b1, acc);
    chk("head_after_pop", 64'(pkt_id),    64'(10'd2));
    chk("full_after_pop", 64'(UpStrFull), 64'(0));
    tick(1'b1, p5, 1'b0, acc);
    chk("fifth_gnt", 64'(GntUpStr), 64'(1));
    tick(1'b1, p5, 1'b0, acc);
    tick(1'b0, '0, 1'b0, acc);
    for (int i = 2; i <= 5; i++) begin
      chk("fill_order", 64'(pkt_id), 64'(i));
      tick(1'b0, '0, 1'b1, acc);
    end

    // Simultaneous push and pop at count 2
    send(mk(10'd20, 6'b000_100), 0);
    send(mk(10'd21, 6'b000_100), 0);
    pc = mk(10'd22, 6'b000_100);
    tick(1'b1, pc, 1'b1, acc);
    chk("simul_head", 64'(pkt_id), 64'(10'd21));
    tick(1'b1, pc, 1'b0, acc);
    tick(1'b0, '0, 1'b0, acc);
    chk("simul_order1", 64'(pkt_id), 64'(10'd21));
    tick(1'b0, '0, 1'b1, acc);
    chk("simul_order2", 64'(pkt_id), 64'(10'd22));
    drain();

    // Asynchronous reset while waiting for the request to drop, three entries queued
    send(mk(10'd30, 6'b000_101), 0);
    send(mk(10'd31, 6'b000_101), 0);
    pc = mk(10'd32, 6'b010_001);
    tick(1'b1, pc, 1'b0, acc);
    tick(1'b1, pc, 1'b0, acc);
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 64'(pkt_valid), 64'(0));
    chk("rst_rx",    64'(rx_count),  64'(0));
    chk("rst_gnt",   64'(GntUpStr),  64'(0));
    chk("rst_full",  64'(UpStrFull), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick(1'b1, pc, 1'b0, acc);
    chk("rst_recapture", 64'(rx_count), 64'(16'd1));
    tick(1'b1, pc, 1'b0, acc);
    tick(1'b0, '0, 1'b1, acc);

    // Sequence checking
`ifdef SEQ_CHECK_EN
    exp_seq = 1;
`else
    exp_seq = 0;
`endif
    send(mk(10'd7,  6'b000_001), 1);
    send(mk(10'd8,  6'b000_001), 1);
    send(mk(10'd10, 6'b000_001), 1);
    chk("seq_gap", 64'(seq_err_count), 64'(exp_seq));
    send(mk(10'd0, 6'b001_000), 1);
    chk("seq_new_src", 64'(seq_err_count), 64'(exp_seq));
    send(mk(10'd1023, 6'b000_011), 1);
    send(mk(10'd0,    6'b000_011), 1);
    chk("seq_wrap", 64'(seq_err_count), 64'(exp_seq));
    drain();

    // Randomized traffic
    for (int i = 0; i < 8; i++) nid[i] = int'($urandom_range(0, 1023));
    for (int n = 0; n < 150; n++) begin
      for (int g = int'($urandom_range(0, 2)); g > 0; g--)
        tick(1'b0, '0, 1'($urandom_range(0, 1)), acc);
      src = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) id = int'($urandom_range(0, 1023));
      else id = nid[src[2:0]];
      nid[src[2:0]] = (id + 1) % 1024;
      send(mk(10'(id), src), 2);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
